// File: rtl/i2c_master_burst.sv
// I2C burst master: START, 7-bit address + R/W, 0..2^LEN_W-1 data bytes, STOP.
// Each bit is four quarters of CLK_DIV clocks; SCL is high in q1/q2, SDA moves at q0, SDA is sampled at q2.
module i2c_master_burst #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned LEN_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rw,
    input  logic [6:0]       slave_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       tx_data,
    output logic             tx_req,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             nack,
    output logic [3:0]       state,
    output logic             sclk,
    output logic             sda_out,
    input  logic             sda_in
);

    localparam int unsigned QW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned QPRE = (CLK_DIV > 1) ? CLK_DIV - 2 : 0;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_START     = 4'd1,
        S_ADDR      = 4'd2,
        S_ADDR_ACK  = 4'd3,
        S_WRITE     = 4'd4,
        S_WRITE_ACK = 4'd5,
        S_READ      = 4'd6,
        S_READ_ACK  = 4'd7,
        S_STOP      = 4'd8
    } state_t;

    state_t           st, st_n;
    logic [QW-1:0]    qcnt, qcnt_n;
    logic [1:0]       quarter, quarter_n;
    logic [2:0]       bitcnt, bit_n;
    logic [7:0]       sh, sh_n;
    logic [LEN_W-1:0] rem, rem_n;
    logic             rw_r, rw_n, ack_r, ack_n;
    logic             busy_n, done_n, nack_n, tx_req_n, rx_valid_n, sclk_n, sda_n;
    logic [7:0]       rx_data_n;
    logic             qend, samp, bit_end, req_slot, ack_now;

    assign state    = st;
    assign qend     = (qcnt == QW'(CLK_DIV - 1));
    assign samp     = (quarter == 2'd2) && (qcnt == '0);
    assign bit_end  = (quarter == 2'd3) && qend;
    // tx_req must sit in the final cycle before a WRITE byte so tx_data is captured on the entry edge
    assign req_slot = (CLK_DIV > 1) ? ((quarter == 2'd3) && (qcnt == QW'(QPRE))) : (quarter == 2'd2);
    assign ack_now  = samp ? sda_in : ack_r;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= S_IDLE;
            qcnt     <= '0;
            quarter  <= '0;
            bitcnt   <= '0;
            sh       <= '0;
            rem      <= '0;
            rw_r     <= 1'b0;
            ack_r    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            nack     <= 1'b0;
            tx_req   <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            sclk     <= 1'b1;
            sda_out  <= 1'b1;
        end else begin
            st       <= st_n;
            qcnt     <= qcnt_n;
            quarter  <= quarter_n;
            bitcnt   <= bit_n;
            sh       <= sh_n;
            rem      <= rem_n;
            rw_r     <= rw_n;
            ack_r    <= ack_n;
            busy     <= busy_n;
            done     <= done_n;
            nack     <= nack_n;
            tx_req   <= tx_req_n;
            rx_valid <= rx_valid_n;
            rx_data  <= rx_data_n;
            sclk     <= sclk_n;
            sda_out  <= sda_n;
        end
    end

    // Next-state, datapath and bus-pin logic; pins derive from the next state so they change with it
    always_comb begin
        st_n       = st;
        qcnt_n     = qend ? '0 : qcnt + QW'(1);
        quarter_n  = quarter + 2'(qend);
        bit_n      = bitcnt;
        sh_n       = sh;
        rem_n      = rem;
        rw_n       = rw_r;
        ack_n      = ack_r;
        busy_n     = busy;
        done_n     = 1'b0;
        nack_n     = nack;
        tx_req_n   = 1'b0;
        rx_valid_n = 1'b0;
        rx_data_n  = rx_data;
        sclk_n     = 1'b1;
        sda_n      = 1'b1;

        case (st)
            S_IDLE: begin
                qcnt_n    = '0;
                quarter_n = '0;
                bit_n     = '0;
                if (start) begin
                    st_n   = S_START;
                    sh_n   = {slave_addr, rw};
                    rw_n   = rw;
                    rem_n  = len;
                    nack_n = 1'b0;
                    busy_n = 1'b1;
                end
            end
            S_START: begin
                if ((quarter == 2'd1) && qend) begin
                    st_n      = S_ADDR;
                    quarter_n = '0;
                end
            end
            S_ADDR, S_WRITE: begin
                if (bit_end) begin
                    if (bitcnt == 3'd7) begin
                        st_n  = (st == S_ADDR) ? S_ADDR_ACK : S_WRITE_ACK;
                        bit_n = '0;
                    end else begin
                        bit_n = bitcnt + 3'd1;
                        sh_n  = {sh[6:0], 1'b0};
                    end
                end
            end
            S_ADDR_ACK: begin
                if (samp) ack_n = sda_in;
                if (req_slot && !ack_now && (rem != '0) && !rw_r) tx_req_n = 1'b1;
                if (bit_end) begin
                    if (ack_now) begin
                        nack_n = 1'b1;
                        st_n   = S_STOP;
                    end else if (rem == '0) begin
                        st_n = S_STOP;
                    end else if (rw_r) begin
                        st_n = S_READ;
                    end else begin
                        st_n = S_WRITE;
                        sh_n = tx_data;
                    end
                end
            end
            S_WRITE_ACK: begin
                if (samp) ack_n = sda_in;
                if (req_slot && !ack_now && (rem != LEN_W'(1))) tx_req_n = 1'b1;
                if (bit_end) begin
                    if (ack_now) begin
                        nack_n = 1'b1;
                        st_n   = S_STOP;
                    end else begin
                        rem_n = rem - LEN_W'(1);
                        if (rem != LEN_W'(1)) begin
                            st_n = S_WRITE;
                            sh_n = tx_data;
                        end else begin
                            st_n = S_STOP;
                        end
                    end
                end
            end
            S_READ: begin
                if (samp) begin
                    sh_n = {sh[6:0], sda_in};
                    if (bitcnt == 3'd7) begin
                        rx_data_n  = {sh[6:0], sda_in};
                        rx_valid_n = 1'b1;
                    end
                end
                if (bit_end) begin
                    if (bitcnt == 3'd7) begin
                        st_n  = S_READ_ACK;
                        bit_n = '0;
                    end else begin
                        bit_n = bitcnt + 3'd1;
                    end
                end
            end
            S_READ_ACK: begin
                if (bit_end) begin
                    rem_n = rem - LEN_W'(1);
                    st_n  = (rem == LEN_W'(1)) ? S_STOP : S_READ;
                end
            end
            S_STOP: begin
                if ((quarter == 2'd2) && qend) begin
                    st_n   = S_IDLE;
                    done_n = 1'b1;
                    busy_n = 1'b0;
                end
            end
            default: st_n = S_IDLE;
        endcase

        case (st_n)
            S_START: sda_n = (quarter_n == 2'd0);
            S_ADDR, S_WRITE: begin
                sclk_n = quarter_n[0] ^ quarter_n[1];
                sda_n  = sh_n[7];
            end
            S_ADDR_ACK, S_WRITE_ACK, S_READ: sclk_n = quarter_n[0] ^ quarter_n[1];
            S_READ_ACK: begin
                sclk_n = quarter_n[0] ^ quarter_n[1];
                sda_n  = (rem_n == LEN_W'(1));
            end
            S_STOP: begin
                sclk_n = (quarter_n != 2'd0);
                sda_n  = (quarter_n == 2'd2);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_i2c_master_burst.sv
// Directed bench for i2c_master_burst with a behavioural slave and bus-bit recorder.
module tb_i2c_master_burst;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] slave_addr = '0;
    logic [3:0] len = '0;
    logic [7:0] tx_data = '0;
    logic       tx_req, rx_valid, busy, done, nack, sclk, sda_out;
    logic [7:0] rx_data;
    logic [3:0] state;
    logic       sda_in = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave configuration set by the stimulus
    logic [7:0] wbytes [0:3];
    logic [7:0] rxb    [0:3];
    logic       rw_t = 1'b0;
    logic       addr_ack_v = 1'b0;
    int         nack_byte = 99;

    // Observations gathered by the monitor
    logic [63:0] fbits = '0;
    int rises = 0, falls = 0, ntx = 0, nrx = 0, ndone = 0;
    logic [7:0] rxv [0:3];
    logic sclk_p = 1'b1, sda_p = 1'b1, pend = 1'b0;

    i2c_master_burst #(.CLK_DIV(2), .LEN_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .slave_addr(slave_addr),
        .len(len), .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy), .done(done), .nack(nack), .state(state),
        .sclk(sclk), .sda_out(sda_out), .sda_in(sda_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic slave_bit(input int k);
        int j, b;
        if (k < 8) return 1'b1;
        if (k == 8) return addr_ack_v;
        j = (k - 9) % 9;
        b = (k - 9) / 9;
        if (rw_t) return (j < 8 && b < 4) ? rxb[b][7-j] : 1'b1;
        return (j == 8) ? (b == nack_byte) : 1'b1;
    endfunction

    function automatic logic [7:0] frame_byte(input int p);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[7-i] = fbits[p+i];
        return v;
    endfunction

    // Slave and bus monitor, evaluated mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            sda_in = 1'b1; sclk_p = 1'b1; sda_p = 1'b1; pend = 1'b0;
            rises = 0; falls = 0; ntx = 0; nrx = 0; ndone = 0; fbits = '0;
        end else begin
            if (start && !busy) begin
                rises = 0; falls = 0; ntx = 0; nrx = 0; ndone = 0; fbits = '0;
                tx_data = wbytes[0]; pend = 1'b0;
            end
            if (pend) begin
                tx_data = wbytes[ntx % 4];
                pend = 1'b0;
            end
            if (tx_req) begin
                ntx++;
                pend = 1'b1;
            end
            if (sclk && !sclk_p) begin
                if (rises < 64) fbits[rises] = sda_out;
                rises++;
            end
            if (!sclk && sclk_p) begin
                sda_in = slave_bit(falls);
                falls++;
            end
            if (rx_valid) begin
                if (nrx < 4) rxv[nrx] = rx_data;
                nrx++;
            end
            if (done) ndone++;
            sclk_p = sclk;
            sda_p  = sda_out;
        end
    end

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [3:0] l);
        @(posedge clk); #1;
        slave_addr = a; rw = r; len = l; rw_t = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if (done) break;
        end
        if (i == 3000) check({tag, "_timeout"}, 64'd0, 64'd1);
        @(negedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin wbytes[i] = '0; rxb[i] = '0; rxv[i] = '0; end

        // Reset state
        #13;
        check("rst_sclk", 64'(sclk), 64'd1);
        check("rst_sda", 64'(sda_out), 64'd1);
        check("rst_state", 64'(state), 64'd0);
        check("rst_busy", 64'({done, tx_req, rx_valid, nack, busy}), 64'd0);
        check("rst_rxdata", 64'(rx_data), 64'h00);
        @(posedge clk); #1 rst = 1'b0;

        // Write: 5A/W, A5, 3C, all ACKed
        wbytes[0] = 8'hA5; wbytes[1] = 8'h3C; addr_ack_v = 1'b0; nack_byte = 99;
        run_txn(7'h5A, 1'b0, 4'd2);
        check("wr_busy", 64'(busy), 64'd1);
        wait_done("wr");
        check("wr_addr", 64'(frame_byte(0)), 64'hB4);
        check("wr_b0", 64'(frame_byte(9)), 64'hA5);
        check("wr_b1", 64'(frame_byte(18)), 64'h3C);
        check("wr_rises", 64'(rises), 64'd28);
        check("wr_txreq", 64'(ntx), 64'd2);
        check("wr_done", 64'(ndone), 64'd1);
        check("wr_nack", 64'(nack), 64'd0);
        check("wr_idle", 64'({busy, state}), 64'd0);

        // Read: 21/R, three bytes, master ACK ACK NACK
        rxb[0] = 8'h11; rxb[1] = 8'h22; rxb[2] = 8'h33;
        run_txn(7'h21, 1'b1, 4'd3);
        wait_done("rd");
        check("rd_addr", 64'(frame_byte(0)), 64'h43);
        check("rd_nrx", 64'(nrx), 64'd3);
        check("rd_b0", 64'(rxv[0]), 64'h11);
        check("rd_b1", 64'(rxv[1]), 64'h22);
        check("rd_b2", 64'(rxv[2]), 64'h33);
        check("rd_mack", 64'({fbits[17], fbits[26], fbits[35]}), 64'b001);
        check("rd_rises", 64'(rises), 64'd37);
        check("rd_nack", 64'(nack), 64'd0);

        // Address NACK
        addr_ack_v = 1'b1;
        run_txn(7'h10, 1'b0, 4'd2);
        wait_done("an");
        check("an_nack", 64'(nack), 64'd1);
        check("an_txrx", 64'(ntx + nrx), 64'd0);
        check("an_rises", 64'(rises), 64'd10);
        check("an_done", 64'(ndone), 64'd1);

        // Mid-burst NACK on second data byte
        addr_ack_v = 1'b0; nack_byte = 1;
        wbytes[0] = 8'h11; wbytes[1] = 8'h22; wbytes[2] = 8'h33; wbytes[3] = 8'h44;
        run_txn(7'h33, 1'b0, 4'd4);
        check("mn_nack_clr", 64'(nack), 64'd0);
        wait_done("mn");
        check("mn_txreq", 64'(ntx), 64'd2);
        check("mn_nack", 64'(nack), 64'd1);
        check("mn_b0", 64'(frame_byte(9)), 64'h11);
        check("mn_b1", 64'(frame_byte(18)), 64'h22);
        check("mn_rises", 64'(rises), 64'd28);

        // Reset in bit 3 of the first data byte
        nack_byte = 99;
        run_txn(7'h3B, 1'b0, 4'd2);
        begin
            int i;
            for (i = 0; i < 3000; i++) begin
                @(posedge clk); #1;
                if (falls >= 14) break;
            end
            if (i == 3000) check("rs_wait_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #2;
        check("rs_pre", 64'({busy, state}), 64'h14);
        rst = 1'b1; #1;
        check("rs_sclk", 64'(sclk), 64'd1);
        check("rs_sda", 64'(sda_out), 64'd1);
        check("rs_state_busy", 64'({busy, state}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wbytes[0] = 8'h96;
        run_txn(7'h3B, 1'b0, 4'd1);
        wait_done("rs2");
        check("rs2_addr", 64'(frame_byte(0)), 64'h76);
        check("rs2_b0", 64'(frame_byte(9)), 64'h96);
        check("rs2_ok", 64'({nack, ntx[3:0], ndone[3:0]}), 64'h011);

        // Probe with an ignored start while busy
        run_txn(7'h48, 1'b0, 4'd0);
        repeat (3) @(posedge clk);
        #1 slave_addr = 7'h7F; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("pr");
        check("pr_addr", 64'(frame_byte(0)), 64'h90);
        check("pr_rises", 64'(rises), 64'd10);
        check("pr_ok", 64'({nack, ntx[3:0], ndone[3:0]}), 64'h001);
        repeat (40) @(posedge clk);
        #1;
        check("pr_quiet", 64'({busy, state}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
